page_alloc_walker: RTL
======================

Name: page_alloc_walker

Overview:
- Sequential page allocator that owns the per-page scoreboard bitmap for a binary page tree.
- On an alloc request it descends the tree one level per clock, taking the preferred child unless that subtree is full, and returns the chosen page index.
- On a free request it clears the page's scoreboard bit.
- Sits directly upstream of the decode-node tree: its registered scoreboard and derived subtree-full bits are the per-node status those nodes consume.

Parameters:
- PAGES, 16, number of pages (tree leaves); power of two, >= 2.
- IDX_W, $clog2(PAGES), page index width; derived, not overridden.

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  reset, asynchronous, active-low
- i_alloc_valid  input  1  alloc request
- o_alloc_ready  output  1  alloc accepted when valid & ready
- i_alloc_inv  input  1  preference: 0 = left/lower child first, 1 = right/upper child first; sampled at accept
- o_rsp_valid  output  1  alloc response valid
- i_rsp_ready  input  1  response consumed when valid & ready
- o_rsp_idx  output  IDX_W  allocated page index
- o_rsp_fail  output  1  1 = no free page, o_rsp_idx = 0
- i_free_valid  input  1  free request
- o_free_ready  output  1  free accepted when valid & ready
- i_free_idx  input  IDX_W  page to free
- o_free_cnt  output  IDX_W+1  count of free pages
- o_full  output  1  o_free_cnt == 0
- o_err  output  1  double-free pulse (macro only; tied 0 otherwise)

Behaviour:
- Reset (async, i_rstn=0):
  - Bitmap all 0 (free); FSM IDLE; level counter 0.
  - o_alloc_ready=1, o_free_ready=1, o_rsp_valid=0, o_rsp_idx=0, o_rsp_fail=0.
  - o_free_cnt=PAGES, o_full=0, o_err=0.
  - Reset mid-walk aborts the walk and discards the pending response.
- Subtree-full derivation: leaf full = bitmap bit; internal node full = AND of its two children (combinational from the registered bitmap).
- FSM states: IDLE, WALK, RESP.
  - o_alloc_ready = (state==IDLE).
  - o_free_ready = (state!=WALK).
- IDLE:
  - Alloc handshake → WALK; lvl=0, path=0, inv latched.
- WALK (one edge per level, lvl 0..IDX_W-1):
  - Fail check: at lvl 0, if root full → RESP with o_rsp_fail=1, o_rsp_idx=0.
  - Child selection: preferred child if not full, else the other child; append the chosen bit (0=left) to path, MSB first.
  - Last level: on the lvl==IDX_W-1 edge, set bitmap[path], decrement o_free_cnt, load o_rsp_idx, go to RESP.
- Latency:
  - Success: o_rsp_valid rises IDX_W edges after the accept edge.
  - Fail: o_rsp_valid rises 1 edge after the accept edge.
- RESP:
  - o_rsp_valid=1; o_rsp_idx and o_rsp_fail held stable until the response handshake.
  - On the handshake edge → IDLE; o_rsp_valid=0 next cycle.
- Free:
  - Accepted in IDLE or RESP.
  - On the accept edge, clear bitmap[i_free_idx]; increment o_free_cnt if the bit was set.
  - Freeing an already-free page does not change the count.
- Simultaneous alloc and free accepted in IDLE:
  - The free applies on the accept edge, so the walk sees the updated bitmap.
  - On a full tree the alloc therefore succeeds and returns the freed index.
- Free in RESP of the page just returned is legal and clears it.
- o_free_cnt, o_full and o_err are registered. o_free_cnt never exceeds PAGES and never underflows; allocation occurs only when the root is not full.

Optional Feature:
- Macro: QPL_DOUBLE_FREE_CHK_EN.
- Defined: a free handshake whose target bit is already 0 pulses o_err high for exactly one cycle after the accept edge. Bitmap and count are unchanged; the handshake still completes.
- Undefined: o_err is tied to 0; a double free is a silent no-op.

Test Plan:
- Reset (PAGES=8) → o_alloc_ready=1, o_free_ready=1, o_free_cnt=8, o_full=0, o_rsp_valid=0.
- 8 allocs, inv=0, i_rsp_ready=1 → o_rsp_idx 0,1,...,7 in order; o_rsp_valid rises 3 edges after each accept; o_free_cnt 8→0; o_full=1.
- Ninth alloc on a full tree → o_rsp_valid 1 edge after accept, o_rsp_fail=1, o_rsp_idx=0; o_free_cnt stays 0.
- After reset: alloc inv=1 → idx 7. Then free idx 7 and alloc inv=0 → idx 0. Hold i_rsp_ready=0 for 3 cycles → o_rsp_valid/o_rsp_idx stable; o_free_ready=1 and o_alloc_ready=0 throughout.
- Full tree, free idx 5 and alloc (inv=0) in the same IDLE cycle → alloc returns idx 5 with fail=0; o_free_cnt ends at 0.
- Macro defined: free idx 2 twice → second free gives a one-cycle o_err=1 and o_free_cnt unchanged. Macro undefined: o_err stays 0.

Source files
------------

// File: rtl/page_alloc_walker.sv
// Sequential binary-tree page allocator: owns the per-page scoreboard bitmap and walks one tree level per clock.
// Optional double-free detection on o_err is enabled by defining QPL_DOUBLE_FREE_CHK_EN.
module page_alloc_walker #(
    parameter int  PAGES = 16,
    localparam int IDX_W = $clog2(PAGES)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_alloc_valid,
    output logic             o_alloc_ready,
    input  logic             i_alloc_inv,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [IDX_W-1:0] o_rsp_idx,
    output logic             o_rsp_fail,
    input  logic             i_free_valid,
    output logic             o_free_ready,
    input  logic [IDX_W-1:0] i_free_idx,
    output logic [IDX_W:0]   o_free_cnt,
    output logic             o_full,
    output logic             o_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] lvl_q, lvl_d;
    logic [IDX_W-1:0] path_q, path_d;
    logic             inv_q, inv_d;
    logic [PAGES-1:0] bm_q, bm_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic             full_q;
    logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
    logic             rsp_fail_q, rsp_fail_d;

    logic             alloc_fire, free_fire;
    logic             root_full, lchild_full, rchild_full, pick;
    int unsigned      shamt;

    assign alloc_fire = i_alloc_valid && (state_q == S_IDLE);
    assign free_fire  = i_free_valid && (state_q != S_WALK);
    assign root_full  = &bm_q;

    // A subtree is full when every leaf under it is taken, which equals the AND of its two children.
    always_comb begin
        lchild_full = 1'b1;
        rchild_full = 1'b1;
        shamt       = 32'(IDX_W - 1) - 32'(lvl_q);
        for (int unsigned i = 0; i < PAGES; i++) begin
            if ((i >> shamt) == 32'({path_q, 1'b0})) lchild_full = lchild_full & bm_q[i[IDX_W-1:0]];
            if ((i >> shamt) == 32'({path_q, 1'b1})) rchild_full = rchild_full & bm_q[i[IDX_W-1:0]];
        end
        pick = inv_q ^ (inv_q ? rchild_full : lchild_full);
    end

    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        path_d     = path_q;
        inv_d      = inv_q;
        bm_d       = bm_q;
        cnt_d      = cnt_q;
        rsp_idx_d  = rsp_idx_q;
        rsp_fail_d = rsp_fail_q;

        // Free lands on its accept edge, so a walk started on the same edge sees the cleared bit.
        if (free_fire) begin
            if (bm_q[i_free_idx]) cnt_d = cnt_q + (IDX_W+1)'(1);
            bm_d[i_free_idx] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (alloc_fire) begin
                    state_d = S_WALK;
                    lvl_d   = '0;
                    path_d  = '0;
                    inv_d   = i_alloc_inv;
                end
            end
            S_WALK: begin
                if (lvl_q == '0 && root_full) begin
                    state_d    = S_RESP;
                    rsp_idx_d  = '0;
                    rsp_fail_d = 1'b1;
                end else begin
                    path_d = (path_q << 1) | IDX_W'(pick);
                    if (lvl_q == IDX_W'(IDX_W - 1)) begin
                        bm_d[path_d] = 1'b1;
                        cnt_d        = cnt_q - (IDX_W+1)'(1);
                        rsp_idx_d    = path_d;
                        rsp_fail_d   = 1'b0;
                        state_d      = S_RESP;
                    end else begin
                        lvl_d = lvl_q + IDX_W'(1);
                    end
                end
            end
            S_RESP: begin
                if (i_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            lvl_q      <= '0;
            path_q     <= '0;
            inv_q      <= 1'b0;
            bm_q       <= '0;
            cnt_q      <= (IDX_W+1)'(PAGES);
            full_q     <= 1'b0;
            rsp_idx_q  <= '0;
            rsp_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            path_q     <= path_d;
            inv_q      <= inv_d;
            bm_q       <= bm_d;
            cnt_q      <= cnt_d;
            full_q     <= (cnt_d == '0);
            rsp_idx_q  <= rsp_idx_d;
            rsp_fail_q <= rsp_fail_d;
        end
    end

`ifdef QPL_DOUBLE_FREE_CHK_EN
    logic err_q;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) err_q <= 1'b0;
        else         err_q <= free_fire && !bm_q[i_free_idx];
    end
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_alloc_ready = (state_q == S_IDLE);
    assign o_free_ready  = (state_q != S_WALK);
    assign o_rsp_valid   = (state_q == S_RESP);
    assign o_rsp_idx     = rsp_idx_q;
    assign o_rsp_fail    = rsp_fail_q;
    assign o_free_cnt    = cnt_q;
    assign o_full        = full_q;

endmodule
